// File: rtl/xmit_pkg.sv
// Shared definitions for the serial frame transmitter: FSM encoding, frame geometry, default header.
// The optional inter-frame gap is selected with the XMIT_GAP_EN macro in xmit.sv.
package xmit_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HEAD = 2'd1;
  localparam state_t ST_BODY = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  localparam int HEAD_BITS = 8;
  localparam int BODY_BITS = 8;

  // Receiver and transmitter must agree on this header byte.
  localparam logic [7:0] DEFAULT_MATCH = 8'hA5;

  function automatic logic [15:0] make_frame(input logic [7:0] match, input logic [7:0] payload);
    return {match, payload};
  endfunction

endpackage

// File: rtl/xmit_fifo.sv
// Two-entry, 8-bit byte buffer in front of the serialiser.
// Writes are refused while full; rdata shows the oldest entry so a pop can capture it on the same edge.
module xmit_fifo (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       rd,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       do_wr;
  logic       do_rd;

  // Acceptance uses the registered full, so a write alongside a pop while full is refused.
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (do_rd) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign full  = count_reg[1];
  assign empty = (count_reg == 2'd0);

endmodule

// File: rtl/xmit.sv
// Serial frame transmitter: sends {MATCH, payload} MSB first, one bit per clock, idling at ~MATCH[7].
// Define XMIT_GAP_EN to insert GAP idle bits after every frame.
module xmit
  import xmit_pkg::*;
#(
  parameter logic [7:0] MATCH = DEFAULT_MATCH
`ifdef XMIT_GAP_EN
  ,
  parameter int GAP = 2
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       serial_out,
  output logic       busy,
  output logic       full,
  output logic       dropped
);

  localparam logic       IDLE_BIT  = ~MATCH[7];
  localparam logic [2:0] HEAD_LAST = 3'(HEAD_BITS - 1);
  localparam logic [2:0] BODY_LAST = 3'(BODY_BITS - 1);
`ifdef XMIT_GAP_EN
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);
  logic [3:0] gap_cnt_reg;
`endif

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] shift_reg;
  logic [2:0]  bit_cnt_reg;
  logic        pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty;

  xmit_fifo u_fifo (
    .clock (clock),
    .reset (reset),
    .wr    (load),
    .wdata (data_in),
    .rd    (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (bit_cnt_reg == HEAD_LAST) begin
          state_next = ST_BODY;
        end
      end
      ST_BODY: begin
        if (bit_cnt_reg == BODY_LAST) begin
`ifdef XMIT_GAP_EN
          state_next = ST_GAP;
`else
          // Next frame starts immediately so the stream stays contiguous.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_HEAD;
          end else begin
            state_next = ST_IDLE;
          end
`endif
        end
      end
`ifdef XMIT_GAP_EN
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_HEAD;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= 16'd0;
      bit_cnt_reg <= 3'd0;
      serial_out  <= IDLE_BIT;
      dropped     <= 1'b0;
`ifdef XMIT_GAP_EN
      gap_cnt_reg <= 4'd0;
`endif
    end else begin
      state_reg <= state_next;
      dropped   <= load && full;
      case (state_reg)
        ST_HEAD, ST_BODY: begin
          serial_out  <= shift_reg[15];
          shift_reg   <= {shift_reg[14:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
`ifdef XMIT_GAP_EN
        ST_GAP: begin
          serial_out  <= IDLE_BIT;
          gap_cnt_reg <= (gap_cnt_reg == GAP_LAST) ? 4'd0 : gap_cnt_reg + 4'd1;
        end
`endif
        default: begin
          serial_out <= IDLE_BIT;
        end
      endcase
      // A pop overrides the shift: the new frame is loaded whole.
      if (pop) begin
        shift_reg   <= make_frame(MATCH, fifo_rdata);
        bit_cnt_reg <= 3'd0;
      end
    end
  end

  assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_xmit.sv
// Bench for xmit: directed scenarios plus random loads, checked each cycle against a bit-stream model.
// Build with XMIT_GAP_EN defined to exercise the gap variant (GAP=3).
module tb_xmit;

  localparam logic [7:0] MATCH    = 8'hA5;
  localparam logic       IDLE_BIT = ~MATCH[7];
`ifdef XMIT_GAP_EN
  localparam int GAP_LEN = 3;
`else
  localparam int GAP_LEN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       load = 1'b0;
  logic       serial_out;
  logic       busy;
  logic       full;
  logic       dropped;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef XMIT_GAP_EN
  xmit #(.MATCH(MATCH), .GAP(GAP_LEN)) dut (
`else
  xmit #(.MATCH(MATCH)) dut (
`endif
    .clock      (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load       (load),
    .serial_out (serial_out),
    .busy       (busy),
    .full       (full),
    .dropped    (dropped)
  );

  // Reference: pending bytes, bits of the frame still to emit, idle gap bits still owed.
  logic [7:0] q[$];
  logic       fb[$];
  int         g = 0;
  logic       m_out = IDLE_BIT;
  logic       m_busy = 1'b0;
  logic       m_full = 1'b0;
  logic       m_dropped = 1'b0;

  task automatic model_step(input logic rst_i, input logic load_i, input logic [7:0] din);
    logic        was_full;
    logic        start;
    logic [7:0]  b;
    logic [15:0] f;
    if (!rst_i) begin
      q.delete();
      fb.delete();
      g = 0;
      m_out = IDLE_BIT;
      m_busy = 1'b0;
      m_full = 1'b0;
      m_dropped = 1'b0;
      return;
    end
    was_full = (q.size() == 2);
    start = 1'b0;
    if (fb.size() > 0) begin
      m_out = fb.pop_front();
      if (fb.size() == 0) begin
        if (GAP_LEN > 0) g = GAP_LEN;
        else start = 1'b1;
      end
    end else if (g > 0) begin
      m_out = IDLE_BIT;
      g = g - 1;
      if (g == 0) start = 1'b1;
    end else begin
      m_out = IDLE_BIT;
      start = 1'b1;
    end
    if (start && q.size() > 0) begin
      b = q.pop_front();
      f = {MATCH, b};
      for (int i = 15; i >= 0; i--) fb.push_back(f[i]);
    end
    if (load_i && !was_full) q.push_back(din);
    m_dropped = load_i && was_full;
    m_full = (q.size() == 2);
    m_busy = (fb.size() > 0) || (g > 0);
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%04h exp=%04h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic       r = reset;
    logic       l = load;
    logic [7:0] d = data_in;
    @(posedge clk);
    model_step(r, l, d);
    #1;
    chk1("serial_out", serial_out, m_out);
    chk1("busy", busy, m_busy);
    chk1("full", full, m_full);
    chk1("dropped", dropped, m_dropped);
  endtask

  task automatic idle_ticks(input int n);
    load = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [15:0] cap;

  initial begin
    // Reset
    reset = 1'b0;
    idle_ticks(3);
    chk1("rst_serial", serial_out, IDLE_BIT);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_full", full, 1'b0);
    chk1("rst_dropped", dropped, 1'b0);
    reset = 1'b1;
    idle_ticks(2);

    // Single byte 3C: frame appears after edges N+2..N+17
    load = 1'b1; data_in = 8'h3C;
    tick();
    load = 1'b0;
    tick();
    chk1("n1_still_idle", serial_out, IDLE_BIT);
    chk1("n1_busy", busy, 1'b1);
    cap = 16'd0;
    for (int k = 0; k < 16; k++) begin
      tick();
      cap = {cap[14:0], serial_out};
    end
    chk16("frame_3c", cap, 16'hA53C);
    idle_ticks(2);
    chk1("after_idle", serial_out, IDLE_BIT);
    idle_ticks(10);

    // Back-to-back 01, FE
    load = 1'b1; data_in = 8'h01; tick();
    data_in = 8'hFE; tick();
    idle_ticks(45);

    // Overflow: three loads fill the buffer, the fourth is dropped
    load = 1'b1; data_in = 8'h11; tick();
    data_in = 8'h22; tick();
    data_in = 8'h33; tick();
    chk1("ovf_full", full, 1'b1);
    data_in = 8'h44; tick();
    chk1("ovf_drop", dropped, 1'b1);
    load = 1'b0; tick();
    chk1("ovf_drop_pulse_end", dropped, 1'b0);
    idle_ticks(70);

    // Payload equal to header, twice
    load = 1'b1; data_in = 8'hA5; tick();
    tick();
    idle_ticks(45);

    // Reset mid-frame
    load = 1'b1; data_in = 8'h5A; tick();
    idle_ticks(8);
    reset = 1'b0;
    idle_ticks(3);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_full", full, 1'b0);
    chk1("midrst_serial", serial_out, IDLE_BIT);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk1("midrst_quiet", serial_out, IDLE_BIT);
    end

    // Random loads with occasional reset
    for (int i = 0; i < 900; i++) begin
      load = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset = 1'b1;
    idle_ticks(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
